stopwatch_seq_ctrl: RTL and testbench

Sequencing controller for the stopwatch datapath. It takes debounced single-cycle key pulses and drives the time counter's enable and clear. It writes lap times into a synchronous lap-record RAM and browses them back to the display. It sits between the key debouncers and the counter, lap RAM and display mux, and owns all run/stop/clear and lap-memory addressing decisions.

---
 rtl/stopwatch_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_stopwatch_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_seq_ctrl
//
// Sequencing controller for the stopwatch datapath. It turns debounced key
// pulses into run/stop/clear control for the time counter. While running it
// records lap times into a synchronous lap RAM. While stopped it browses the
// stored laps back to the display, oldest first.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_start   in   one-cycle pulse: START / STOP / RESET key
//   key_record  in   one-cycle pulse: lap record (RUN) / browse (STOP)
//   cnt_time    in   live counter value
//   ram_rdata   in   lap RAM read data, valid one cycle after ram_rden
//   cnt_en      out  counter enable, high in RUN
//   cnt_clr     out  counter clear, one-cycle pulse in CLEAR
//   ram_addr    out  lap RAM address (registered)
//   ram_wren    out  lap RAM write strobe
//   ram_rden    out  lap RAM read strobe
//   ram_wdata   out  lap RAM write data
//   disp_out    out  value to display
//   lap_count   out  number of stored laps, 0..DEPTH
//   state_o     out  IDLE=00 RUN=01 STOP=10 CLEAR=11
// -----------------------------------------------------------------------------
module stopwatch_seq_ctrl #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_record,
    input  logic [DATA_W-1:0] cnt_time,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              ram_rden,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] disp_out,
    output logic [ADDR_W:0]   lap_count,
    output logic [1:0]        state_o
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STOP  = 2'b10,
        S_CLEAR = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
    logic [ADDR_W:0]     lap_cnt_q, lap_cnt_d;
    logic                browse_q, browse_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_wren_q, ram_wren_d;
    logic                ram_rden_q, ram_rden_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   disp_q, disp_d;

    logic                rec_ok;
    logic                do_wr;
    logic                do_rd;
    logic [ADDR_W-1:0]   oldest;
    logic [ADDR_W-1:0]   rd_addr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (key_start) state_d = S_RUN;
            S_RUN:   if (key_start) state_d = S_STOP;
            S_STOP:  if (key_start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cnt_en  = (state_q == S_RUN);
        cnt_clr = (state_q == S_CLEAR);
        state_o = state_q;
    end

    // ---------------- lap memory sequencing ----------------
    always_comb begin
        // key_start has priority: a record pulse in the same cycle is dropped
        rec_ok  = key_record && !key_start;
        do_wr   = rec_ok && (state_q == S_RUN);
        do_rd   = rec_ok && (state_q == S_STOP) && (lap_cnt_q != '0);

        // once the ring has wrapped, the oldest lap sits at the write pointer
        oldest  = (lap_cnt_q == FULL) ? wr_ptr_q : '0;
        rd_addr = oldest + rd_idx_q;

        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        lap_cnt_d  = lap_cnt_q;
        browse_d   = browse_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        ram_wren_d = do_wr;
        ram_rden_d = do_rd;
        // read data arrives the cycle after the strobe; capture it at that edge
        rd_vld_d   = ram_rden_q;

        if (do_wr) begin
            ram_addr_d = wr_ptr_q;
            wdata_d    = cnt_time;
            wr_ptr_d   = wr_ptr_q + ONE_A;
            if (lap_cnt_q != FULL) begin
                lap_cnt_d = lap_cnt_q + ONE_L;
            end
        end

        if (do_rd) begin
            ram_addr_d = rd_addr;
            rd_idx_d   = ({1'b0, rd_idx_q} == (lap_cnt_q - ONE_L)) ? '0 : rd_idx_q + ONE_A;
            browse_d   = 1'b1;
        end

        if (state_d == S_CLEAR) begin
            wr_ptr_d  = '0;
            rd_idx_d  = '0;
            lap_cnt_d = '0;
            browse_d  = 1'b0;
        end

        // display source; blanking on IDLE/CLEAR also drops any read still in flight
        disp_d = disp_q;
        if (state_d == S_IDLE || state_d == S_CLEAR) begin
            disp_d = '0;
        end else if (state_q == S_RUN) begin
            disp_d = cnt_time;
        end else if (state_q == S_STOP && browse_q && rd_vld_q) begin
            disp_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            lap_cnt_q  <= '0;
            browse_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_wren_q <= 1'b0;
            ram_rden_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            wdata_q    <= '0;
            disp_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_idx_q   <= rd_idx_d;
            lap_cnt_q  <= lap_cnt_d;
            browse_q   <= browse_d;
            ram_addr_q <= ram_addr_d;
            ram_wren_q <= ram_wren_d;
            ram_rden_q <= ram_rden_d;
            rd_vld_q   <= rd_vld_d;
            wdata_q    <= wdata_d;
            disp_q     <= disp_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wren  = ram_wren_q;
    assign ram_rden  = ram_rden_q;
    assign ram_wdata = wdata_q;
    assign disp_out  = disp_q;
    assign lap_count = lap_cnt_q;

endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_seq_ctrl
//
// Bench for stopwatch_seq_ctrl with a behavioural synchronous lap RAM.
// Expected RAM writes, RAM reads and display values are queued when the key
// pulse is driven and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_stopwatch_seq_ctrl;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              key_start;
    logic              key_record;
    logic [DATA_W-1:0] cnt_time;
    logic [DATA_W-1:0] ram_rdata;
    logic              cnt_en;
    logic              cnt_clr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] disp_out;
    logic [ADDR_W:0]   lap_count;
    logic [1:0]        state_o;

    stopwatch_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_start  (key_start),
        .key_record (key_record),
        .cnt_time   (cnt_time),
        .ram_rdata  (ram_rdata),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .ram_rden   (ram_rden),
        .ram_wdata  (ram_wdata),
        .disp_out   (disp_out),
        .lap_count  (lap_count),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural lap RAM
    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        if (ram_rden) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    exp_t dq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic push_wr(input int a, input int d);
        exp_t e;
        e.a = 32'(a); e.d = 32'(d); e.cyc = cyc + 1;
        wr_q.push_back(e);
    endtask

    task automatic push_rd(input int a);
        exp_t e;
        e.a = 32'(a); e.d = '0; e.cyc = cyc + 1;
        rd_q.push_back(e);
    endtask

    task automatic push_disp(input int d);
        exp_t e;
        e.a = '0; e.d = 32'(d); e.cyc = cyc + 3;
        dq.push_back(e);
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (ram_wren) begin
            if (wr_q.size() == 0) chk_val("unexpected_wren", 32'(ram_addr), 32'hFFFF_FFFF);
            else begin
                e = wr_q.pop_front();
                chk_val("wr_addr", 32'(ram_addr), e.a);
                chk_val("wr_data", 32'(ram_wdata), e.d);
                chk_val("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ram_rden) begin
            if (rd_q.size() == 0) chk_val("unexpected_rden", 32'(ram_addr), 32'hFFFF_FFFF);
            else begin
                e = rd_q.pop_front();
                chk_val("rd_addr", 32'(ram_addr), e.a);
                chk_val("rd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            e = dq.pop_front();
            chk_val("disp_lap", 32'(disp_out), e.d);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // keys set 1 time unit after an edge, sampled at the next edge
    task automatic pulse(input logic s, input logic r);
        key_start  = s;
        key_record = r;
        @(posedge clk);
        #1;
        key_start  = 1'b0;
        key_record = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        key_start  = 1'b0;
        key_record = 1'b0;
        cnt_time   = '0;
        tick(2);
        chk_val("rst_state", 32'(state_o), 32'h0);
        chk_val("rst_cnt_en", 32'(cnt_en), 32'h0);
        chk_val("rst_cnt_clr", 32'(cnt_clr), 32'h0);
        chk_val("rst_wren", 32'(ram_wren), 32'h0);
        chk_val("rst_rden", 32'(ram_rden), 32'h0);
        chk_val("rst_disp", 32'(disp_out), 32'h0);
        chk_val("rst_laps", 32'(lap_count), 32'h0);
        chk_val("rst_addr", 32'(ram_addr), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // state walk with 4-cycle gaps
        cnt_time = 24'h000123;
        pulse(1'b1, 1'b0);
        chk_val("walk_run_state", 32'(state_o), 32'h1);
        chk_val("walk_run_en", 32'(cnt_en), 32'h1);
        tick(4);
        chk_val("walk_run_disp", 32'(disp_out), 32'h123);
        chk_val("walk_run_clr", 32'(cnt_clr), 32'h0);
        pulse(1'b1, 1'b0);
        chk_val("walk_stop_state", 32'(state_o), 32'h2);
        chk_val("walk_stop_en", 32'(cnt_en), 32'h0);
        cnt_time = 24'h000456;
        tick(4);
        chk_val("walk_stop_hold", 32'(disp_out), 32'h123);
        pulse(1'b1, 1'b0);
        chk_val("walk_clear_state", 32'(state_o), 32'h3);
        chk_val("walk_clear_clr", 32'(cnt_clr), 32'h1);
        chk_val("walk_clear_en", 32'(cnt_en), 32'h0);
        tick(1);
        chk_val("walk_idle_state", 32'(state_o), 32'h0);
        chk_val("walk_idle_clr", 32'(cnt_clr), 32'h0);
        chk_val("walk_idle_laps", 32'(lap_count), 32'h0);
        chk_val("walk_idle_disp", 32'(disp_out), 32'h0);
        tick(3);

        // two records
        pulse(1'b1, 1'b0);
        cnt_time = 24'h000105;
        push_wr(0, 'h105);
        pulse(1'b0, 1'b1);
        cnt_time = 24'h000230;
        push_wr(1, 'h230);
        pulse(1'b0, 1'b1);
        chk_val("two_laps", 32'(lap_count), 32'h2);
        tick(2);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk_val("two_clear_laps", 32'(lap_count), 32'h0);
        tick(2);

        // ten records into an 8-deep ring, then browse nine times
        pulse(1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cnt_time = DATA_W'(i);
            push_wr((i - 1) % DEPTH, i);
            pulse(1'b0, 1'b1);
        end
        chk_val("ring_laps", 32'(lap_count), 32'(DEPTH));
        pulse(1'b1, 1'b0);
        tick(1);
        chk_val("ring_stop_disp", 32'(disp_out), 32'd10);
        for (int k = 0; k < 9; k++) begin
            push_rd((2 + k) % DEPTH);
            push_disp((k % DEPTH) + 3);
            pulse(1'b0, 1'b1);
        end
        tick(4);
        chk_val("ring_disp_hold", 32'(disp_out), 32'd3);
        // read in flight when the clear arrives must not reach the display
        push_rd(3);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        chk_val("flight_clear_state", 32'(state_o), 32'h3);
        chk_val("flight_clear_disp", 32'(disp_out), 32'h0);
        tick(1);
        chk_val("flight_idle_disp", 32'(disp_out), 32'h0);
        chk_val("flight_idle_laps", 32'(lap_count), 32'h0);
        tick(2);

        // simultaneous keys in RUN
        pulse(1'b1, 1'b0);
        cnt_time = 24'h000055;
        push_wr(0, 'h55);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        chk_val("simul_state", 32'(state_o), 32'h2);
        chk_val("simul_laps", 32'(lap_count), 32'h1);
        tick(2);
        pulse(1'b1, 1'b0);
        tick(2);

        // ignored records: IDLE, and STOP with no laps
        pulse(1'b0, 1'b1);
        tick(2);
        chk_val("idle_rec_state", 32'(state_o), 32'h0);
        chk_val("idle_rec_laps", 32'(lap_count), 32'h0);
        chk_val("idle_rec_disp", 32'(disp_out), 32'h0);
        cnt_time = 24'h000777;
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        tick(3);
        chk_val("empty_browse_disp", 32'(disp_out), 32'h777);
        chk_val("empty_browse_state", 32'(state_o), 32'h2);
        pulse(1'b1, 1'b0);
        tick(2);

        // asynchronous reset while a write strobe is high
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cnt_time = DATA_W'(24'h000A00 + i);
            push_wr(i, 'hA00 + i);
            pulse(1'b0, 1'b1);
        end
        chk_val("pre_rst_laps", 32'(lap_count), 32'h3);
        cnt_time   = 24'h000BBB;
        key_record = 1'b1;
        @(posedge clk);
        #1;
        key_record = 1'b0;
        chk_val("pre_rst_wren", 32'(ram_wren), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("async_rst_wren", 32'(ram_wren), 32'h0);
        chk_val("async_rst_state", 32'(state_o), 32'h0);
        chk_val("async_rst_laps", 32'(lap_count), 32'h0);
        chk_val("async_rst_en", 32'(cnt_en), 32'h0);
        chk_val("async_rst_disp", 32'(disp_out), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        chk_val("wr_queue_empty", 32'(wr_q.size()), 32'h0);
        chk_val("rd_queue_empty", 32'(rd_q.size()), 32'h0);
        chk_val("disp_queue_empty", 32'(dq.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
